// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: common data bus transmit side; holds one completed result per FU and broadcasts up to CDB_WIDTH per cycle
// Ports: clock/reset (sync, active-low); flush_i drops all held results;
//   fu_done_valid_i/tag_i/rob_idx_i + fu_done_ready_o form the per-FU result handshake;
//   cdb_valid_o/tag_o/rob_idx_o are the registered broadcast lanes.
// Define CDB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module cdb_broadcaster #(
  parameter int PHYS_REGS = 128,
  parameter int CDB_WIDTH = 2,
  parameter int FU_NUM    = 8,
  parameter int ROB_DEPTH = 32,
  localparam int PRW  = $clog2(PHYS_REGS),
  localparam int ROBW = $clog2(ROB_DEPTH)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush_i,
  input  logic [FU_NUM-1:0]              fu_done_valid_i,
  input  logic [FU_NUM-1:0][PRW-1:0]     fu_done_tag_i,
  input  logic [FU_NUM-1:0][ROBW-1:0]    fu_done_rob_idx_i,
  output logic [FU_NUM-1:0]              fu_done_ready_o,
  output logic [CDB_WIDTH-1:0]           cdb_valid_o,
  output logic [CDB_WIDTH-1:0][PRW-1:0]  cdb_tag_o,
  output logic [CDB_WIDTH-1:0][ROBW-1:0] cdb_rob_idx_o
);
  localparam int FW = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
  logic [FU_NUM-1:0]              slot_v_q, slot_v_d;
  logic [FU_NUM-1:0][PRW-1:0]     slot_tag_q, slot_tag_d;
  logic [FU_NUM-1:0][ROBW-1:0]    slot_rob_q, slot_rob_d;
  logic [CDB_WIDTH-1:0]           cdb_valid_d;
  logic [CDB_WIDTH-1:0][PRW-1:0]  cdb_tag_d;
  logic [CDB_WIDTH-1:0][ROBW-1:0] cdb_rob_d;
  logic [FU_NUM-1:0]              grant, accept;
  logic [FW-1:0]                  start, idx;
  logic                           found;
`ifndef CDB_FIXED_PRIO_EN
  logic [FW-1:0]                  rr_ptr_q, rr_ptr_d, last;
  assign start = rr_ptr_q;
`else
  assign start = '0;
`endif
  // Each lane takes the first still-ungranted valid slot scanning upward from start,
  // so lanes fill from 0 with no gaps and lane order follows scan order.
  always_comb begin
    grant       = '0;
    cdb_valid_d = '0;
    cdb_tag_d   = '0;
    cdb_rob_d   = '0;
    idx         = '0;
    found       = 1'b0;
`ifndef CDB_FIXED_PRIO_EN
    last        = rr_ptr_q;
`endif
    for (int k = 0; k < CDB_WIDTH; k++) begin
      found = 1'b0;
      for (int i = 0; i < FU_NUM; i++) begin
        idx = FW'((int'(start) + i) % FU_NUM);
        if (!flush_i && !found && slot_v_q[idx] && !grant[idx]) begin
          found          = 1'b1;
          grant[idx]     = 1'b1;
          cdb_valid_d[k] = 1'b1;
          cdb_tag_d[k]   = slot_tag_q[idx];
          cdb_rob_d[k]   = slot_rob_q[idx];
`ifndef CDB_FIXED_PRIO_EN
          last           = idx;
`endif
        end
      end
    end
  end
  // A granted slot drains this edge, so it may refill in the same cycle.
  assign fu_done_ready_o = {FU_NUM{reset && !flush_i}} & (~slot_v_q | grant);
  assign accept          = fu_done_valid_i & fu_done_ready_o;
  always_comb begin
    slot_v_d   = flush_i ? '0 : (accept | (slot_v_q & ~grant));
    slot_tag_d = slot_tag_q;
    slot_rob_d = slot_rob_q;
    for (int f = 0; f < FU_NUM; f++) begin
      slot_tag_d[f] = accept[f] ? fu_done_tag_i[f] : slot_tag_q[f];
      slot_rob_d[f] = accept[f] ? fu_done_rob_idx_i[f] : slot_rob_q[f];
    end
`ifndef CDB_FIXED_PRIO_EN
    rr_ptr_d = flush_i ? '0 : (|grant) ? FW'((int'(last) + 1) % FU_NUM) : rr_ptr_q;
`endif
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_v_q      <= '0;
      slot_tag_q    <= '0;
      slot_rob_q    <= '0;
      cdb_valid_o   <= '0;
      cdb_tag_o     <= '0;
      cdb_rob_idx_o <= '0;
`ifndef CDB_FIXED_PRIO_EN
      rr_ptr_q      <= '0;
`endif
    end else begin
      slot_v_q      <= slot_v_d;
      slot_tag_q    <= slot_tag_d;
      slot_rob_q    <= slot_rob_d;
      cdb_valid_o   <= cdb_valid_d;
      cdb_tag_o     <= cdb_tag_d;
      cdb_rob_idx_o <= cdb_rob_d;
`ifndef CDB_FIXED_PRIO_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
    end
  end
endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb_cdb_broadcaster: directed self-checking bench for cdb_broadcaster
module tb_cdb_broadcaster;
  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic [7:0]      fu_v = '0;
  logic [7:0][6:0] fu_tag = '0;
  logic [7:0][4:0] fu_rob = '0;
  logic [7:0]      ready;
  logic [1:0]      cdb_v;
  logic [1:0][6:0] cdb_tag;
  logic [1:0][4:0] cdb_rob;
  int              checks = 0;
  int              errors = 0;
  cdb_broadcaster dut (
    .clock(clock),
    .reset(reset),
    .flush_i(flush),
    .fu_done_valid_i(fu_v),
    .fu_done_tag_i(fu_tag),
    .fu_done_rob_idx_i(fu_rob),
    .fu_done_ready_o(ready),
    .cdb_valid_o(cdb_v),
    .cdb_tag_o(cdb_tag),
    .cdb_rob_idx_o(cdb_rob)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_pair(input string tag, input logic [6:0] t0, input logic [6:0] t1);
    chk({tag, "_v"}, 32'(cdb_v), 32'h3);
    chk({tag, "_t0"}, 32'(cdb_tag[0]), 32'(t0));
    chk({tag, "_t1"}, 32'(cdb_tag[1]), 32'(t1));
  endtask
  initial begin
    // reset held with all FUs requesting
    fu_v = 8'hFF;
    for (int f = 0; f < 8; f++) begin
      fu_tag[f] = 7'(f + 100);
      fu_rob[f] = 5'(f + 20);
    end
    #1;
    chk("rst_ready", 32'(ready), 32'h0);
    tick;
    chk("rst_v0", 32'(cdb_v), 32'h0);
    chk("rst_ready1", 32'(ready), 32'h0);
    tick;
    chk("rst_v1", 32'(cdb_v), 32'h0);
    chk("rst_tag", 32'(cdb_tag), 32'h0);
    chk("rst_rob", 32'(cdb_rob), 32'h0);
    reset = 1'b1;
    fu_v = '0;
    #1;
    chk("post_rst_ready", 32'(ready), 32'hFF);
    tick;
    chk("post_rst_v", 32'(cdb_v), 32'h0);
    // single FU3 result
    fu_v = 8'h08;
    fu_tag[3] = 7'd17;
    fu_rob[3] = 5'd5;
    tick;
    fu_v = '0;
    chk("fu3_c1_v", 32'(cdb_v), 32'h0);
    tick;
    chk("fu3_c2_v", 32'(cdb_v), 32'h1);
    chk("fu3_c2_tag", 32'(cdb_tag[0]), 32'd17);
    chk("fu3_c2_rob", 32'(cdb_rob[0]), 32'd5);
    chk("fu3_c2_tag1", 32'(cdb_tag[1]), 32'd0);
    tick;
    chk("fu3_c3_v", 32'(cdb_v), 32'h0);
    // flush returns the round-robin pointer to 0
    flush = 1'b1;
    #1;
    chk("flush_ready", 32'(ready), 32'h0);
    tick;
    flush = 1'b0;
    // three results, two lanes
    fu_v = 8'h07;
    fu_tag[0] = 7'd10; fu_tag[1] = 7'd11; fu_tag[2] = 7'd12;
    fu_rob[0] = 5'd1;  fu_rob[1] = 5'd2;  fu_rob[2] = 5'd3;
    tick;
    fu_v = '0;
    #1;
    chk("three_c1_ready", 32'(ready), 32'hFB);
    tick;
    chk_pair("three_c2", 7'd10, 7'd11);
    chk("three_c2_rob1", 32'(cdb_rob[1]), 32'd2);
    tick;
    chk("three_c3_v", 32'(cdb_v), 32'h1);
    chk("three_c3_tag", 32'(cdb_tag[0]), 32'd12);
    chk("three_c3_rob", 32'(cdb_rob[0]), 32'd3);
    tick;
    chk("three_c4_v", 32'(cdb_v), 32'h0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    // all eight FUs refilled continuously
    for (int f = 0; f < 8; f++) begin
      fu_tag[f] = 7'(f + 40);
      fu_rob[f] = 5'(f);
    end
    fu_v = 8'hFF;
    tick;
    #1;
    chk("rr_c1_ready", 32'(ready), 32'h03);
    tick;
    chk_pair("rr_c2", 7'd40, 7'd41);
    chk("rr_c2_ready", 32'(ready), 32'h0C);
    tick;
    chk_pair("rr_c3", 7'd42, 7'd43);
    tick;
    chk_pair("rr_c4", 7'd44, 7'd45);
    tick;
    chk_pair("rr_c5", 7'd46, 7'd47);
    chk("rr_c5_rob1", 32'(cdb_rob[1]), 32'd7);
    tick;
    chk_pair("rr_c6", 7'd40, 7'd41);
    fu_v = '0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    // flush drops held results and same-cycle requests
    fu_v = 8'h22;
    fu_tag[1] = 7'd21;
    fu_tag[5] = 7'd25;
    tick;
    fu_v = 8'h01;
    fu_tag[0] = 7'd30;
    flush = 1'b1;
    #1;
    chk("fl_ready", 32'(ready), 32'h0);
    tick;
    flush = 1'b0;
    fu_v = '0;
    chk("fl_c1_v", 32'(cdb_v), 32'h0);
    #1;
    chk("fl_empty_ready", 32'(ready), 32'hFF);
    tick;
    chk("fl_c2_v", 32'(cdb_v), 32'h0);
    tick;
    chk("fl_c3_v", 32'(cdb_v), 32'h0);
    // back-to-back drain and refill of FU4
    fu_v = 8'h10;
    fu_tag[4] = 7'd50;
    fu_rob[4] = 5'd9;
    tick;
    fu_tag[4] = 7'd51;
    fu_rob[4] = 5'd10;
    #1;
    chk("bb_c1_ready", 32'(ready), 32'hFF);
    tick;
    chk("bb_c2_v", 32'(cdb_v), 32'h1);
    chk("bb_c2_tag", 32'(cdb_tag[0]), 32'd50);
    chk("bb_c2_rob", 32'(cdb_rob[0]), 32'd9);
    fu_tag[4] = 7'd52;
    fu_rob[4] = 5'd11;
    #1;
    chk("bb_c2_ready", 32'(ready), 32'hFF);
    tick;
    fu_v = '0;
    chk("bb_c3_v", 32'(cdb_v), 32'h1);
    chk("bb_c3_tag", 32'(cdb_tag[0]), 32'd51);
    chk("bb_c3_rob", 32'(cdb_rob[0]), 32'd10);
    tick;
    chk("bb_c4_v", 32'(cdb_v), 32'h1);
    chk("bb_c4_tag", 32'(cdb_tag[0]), 32'd52);
    tick;
    chk("bb_c5_v", 32'(cdb_v), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
